mem_arbiter: RTL and testbench

Single-port memory arbiter between the CPU's instruction-fetch and data-access requesters, sitting between the pipeline and the one SRAM-like memory/cache port. It serialises both requesters onto the shared port one transaction at a time, and holds returned data until the pipeline advances. It generates `i_stall` and `d_stall`, which the hazard unit folds into `i_longest_stall` / `d_longest_stall`.

---
 rtl/mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter
// ----------------------------------------------------------------------------
// This module arbitrates between the CPU instruction-fetch requester and the
// data-access requester for one shared SRAM-like memory port. It runs one
// downstream transaction at a time. Returned data is held in the inst_rdata
// and data_rdata registers until the pipeline advances.
//
// Configuration macro:
//   MEM_ARB_ROUND_ROBIN_EN  When defined, a tie between simultaneous
//                           candidates is granted to the requester opposite
//                           the previous tie winner. The first tie after
//                           reset goes to data. When undefined, data always
//                           wins a tie.
//
// Ports:
//   clk, rst            rising-edge clock; synchronous active-high reset
//   inst_req/addr       fetch request (read only), held while i_stall
//   inst_rdata          latched fetch data
//   i_stall             fetch not yet complete for this pipeline cycle
//   data_req/wr/size/
//   data_addr/wdata     load/store request, held while d_stall
//   data_rdata          latched load data
//   d_stall             data access not yet complete
//   longest_stall       pipeline-wide stall; low = pipeline advances this edge
//   mem_req/wr/size/
//   mem_addr/wdata      downstream request, registered and stable in ADDR
//   mem_addr_ok         downstream accepts the request (mem_req & mem_addr_ok)
//   mem_data_ok         read data / write ack valid this cycle
//   mem_rdata           downstream read data
//
// Downstream handshake: in ADDR, mem_req is held high and every mem_* field
// stays constant until a cycle with mem_addr_ok = 1; that cycle transfers the
// request. The arbiter then waits in WAIT for exactly one cycle with
// mem_data_ok = 1. A mem_data_ok outside WAIT has no owner and is ignored.
// ============================================================================
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        i_stall,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        d_stall,

    input  logic        longest_stall,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // fsm_state is the observable FSM state; state_next is its combinational
    // successor.
    state_t      fsm_state;
    state_t      state_next;

    logic        owner;        // 0 = inst, 1 = data
    logic        owner_next;
    logic        inst_done;
    logic        data_done;

    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        inst_cand;
    logic        data_cand;
    logic        grant_data;
    logic        load;
    logic        complete;
    logic        owner_req;
    logic        owner_is_read;

    // A requester that has already completed in this pipeline cycle is not a
    // candidate. This also keeps a done-flag clear from colliding with a new
    // grant for the same requester.
    assign inst_cand = inst_req & ~inst_done;
    assign data_cand = data_req & ~data_done;

    assign i_stall   = inst_cand;
    assign d_stall   = data_cand;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // last_win records the winner of the most recent contested grant
    // (0 = inst, 1 = data). A tie goes to the other requester.
    logic last_win;

    assign grant_data = data_cand & (~inst_cand | ~last_win);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_win <= 1'b0;
        end else if (load && inst_cand && data_cand) begin
            last_win <= grant_data;
        end
    end
`else
    // Data is always the older instruction, so it wins any tie.
    assign grant_data = data_cand;
`endif

    // Compute the next state and the one-cycle load/complete strobes.
    always_comb begin
        state_next = fsm_state;
        owner_next = owner;
        load       = 1'b0;
        complete   = 1'b0;
        case (fsm_state)
            S_IDLE: begin
                if (inst_cand || data_cand) begin
                    load       = 1'b1;
                    owner_next = grant_data;
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (mem_addr_ok) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_data_ok) begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // If the owner dropped its request mid-transaction, the result is dropped
    // too: no done flag is set and no data is latched.
    assign owner_req     = owner ? data_req : inst_req;
    assign owner_is_read = ~owner | ~wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_state  <= S_IDLE;
            owner      <= 1'b0;
            inst_done  <= 1'b0;
            data_done  <= 1'b0;
            inst_rdata <= 32'd0;
            data_rdata <= 32'd0;
            wr_q       <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else begin
            fsm_state <= state_next;
            owner     <= owner_next;

            // Fetches are always full-word reads.
            if (load) begin
                wr_q    <= grant_data ? data_wr    : 1'b0;
                size_q  <= grant_data ? data_size  : 2'd2;
                addr_q  <= grant_data ? data_addr  : inst_addr;
                wdata_q <= grant_data ? data_wdata : 32'd0;
            end

            // Pipeline advance starts a new pipeline cycle, so both done flags
            // clear. The latched rdata keeps its value.
            if (!longest_stall) begin
                inst_done <= 1'b0;
                data_done <= 1'b0;
            end else if (complete && owner_req) begin
                if (owner) begin
                    data_done <= 1'b1;
                end else begin
                    inst_done <= 1'b1;
                end
            end

            if (complete && owner_req && owner_is_read) begin
                if (owner) begin
                    data_rdata <= mem_rdata;
                end else begin
                    inst_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_req   = (fsm_state == S_ADDR);
    assign mem_wr    = wr_q;
    assign mem_size  = size_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter
// ----------------------------------------------------------------------------
// Directed testbench for mem_arbiter. A negedge responder models the memory:
// it accepts after addr_lat waiting cycles and returns data data_lat cycles
// after acceptance. Read data comes from a fixed lookup table. Each accepted
// address is logged in grant_q so the tests can check grant order.
// longest_stall follows i_stall | d_stall unless a test overrides it.
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'd0;
    logic [31:0] inst_rdata;
    logic        i_stall;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = 32'd0;
    logic [31:0] data_wdata = 32'd0;
    logic [31:0] data_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    logic        ls_auto = 1'b1;
    logic        ls_manual = 1'b1;
    assign longest_stall = ls_auto ? (i_stall | d_stall) : ls_manual;

    int tests_run = 0;
    int tests_failed = 0;

    int addr_lat = 0;
    int data_lat = 0;
    int rsp_phase = 0;
    int rsp_cnt = 0;
    logic [31:0] rsp_addr = 32'd0;
    logic [31:0] grant_q[$];

    mem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_rdata    (inst_rdata),
        .i_stall       (i_stall),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_rdata    (data_rdata),
        .d_stall       (d_stall),
        .longest_stall (longest_stall),
        .mem_req       (mem_req),
        .mem_wr        (mem_wr),
        .mem_size      (mem_size),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_addr_ok   (mem_addr_ok),
        .mem_data_ok   (mem_data_ok),
        .mem_rdata     (mem_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    // ---------------- memory responder ----------------
    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        case (a)
            32'hBFC00000: return 32'h24080001;
            32'h80001000: return 32'hDEADBEEF;
            default:      return a ^ 32'h5A5A5A5A;
        endcase
    endfunction

    always @(negedge clk) begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        if (rsp_phase == 0) begin
            if (mem_req === 1'b1) begin
                if (rsp_cnt == addr_lat) begin
                    mem_addr_ok = 1'b1;
                    grant_q.push_back(mem_addr);
                    rsp_addr  = mem_addr;
                    rsp_phase = 1;
                    rsp_cnt   = 0;
                end else begin
                    rsp_cnt++;
                end
            end
        end else begin
            if (rsp_cnt == data_lat) begin
                mem_data_ok = 1'b1;
                mem_rdata   = mem_lookup(rsp_addr);
                rsp_phase   = 0;
                rsp_cnt     = 0;
            end else begin
                rsp_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tests_run++;
        if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        tests_run++;
        if (mem_wr !== 1'b0 || mem_size !== 2'd0) begin tests_failed++; $display("FAIL reset_wr_size: got %b/%0d expected 0/0", mem_wr, mem_size); end
        tests_run++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin tests_failed++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", mem_addr, mem_wdata); end
        tests_run++;
        if (inst_rdata !== 32'd0 || data_rdata !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata: got %h/%h expected 0/0", inst_rdata, data_rdata); end
        tests_run++;
        if (i_stall !== 1'b0 || d_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall_idle: got %b/%b expected 0/0", i_stall, d_stall); end
        // The done flags must be clear, so a new request stalls at once.
        inst_req = 1'b1;
        data_req = 1'b1;
        #1;
        tests_run++;
        if (i_stall !== 1'b1 || d_stall !== 1'b1) begin tests_failed++; $display("FAIL reset_stall_req: got %b/%b expected 1/1", i_stall, d_stall); end
        inst_req = 1'b0;
        data_req = 1'b0;
        tick;
    endtask

    task automatic test_single_fetch;
        addr_lat  = 0;
        data_lat  = 0;
        inst_req  = 1'b1;
        inst_addr = 32'hBFC00000;
        #1;
        tests_run++;
        if (i_stall !== 1'b1 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL fetch_c0: got i_stall=%b mem_req=%b expected 1/0", i_stall, mem_req); end
        tick;
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hBFC00000) begin tests_failed++; $display("FAIL fetch_c1_req: got %b %h expected 1 bfc00000", mem_req, mem_addr); end
        tests_run++;
        if (mem_wr !== 1'b0 || mem_size !== 2'd2) begin tests_failed++; $display("FAIL fetch_c1_wr_size: got %b/%0d expected 0/2", mem_wr, mem_size); end
        tick;
        tests_run++;
        if (mem_req !== 1'b0 || i_stall !== 1'b1) begin tests_failed++; $display("FAIL fetch_c2: got mem_req=%b i_stall=%b expected 0/1", mem_req, i_stall); end
        tick;
        tests_run++;
        if (i_stall !== 1'b0) begin tests_failed++; $display("FAIL fetch_c3_stall: got %b expected 0", i_stall); end
        tests_run++;
        if (inst_rdata !== 32'h24080001) begin tests_failed++; $display("FAIL fetch_c3_rdata: got %h expected 24080001", inst_rdata); end
        inst_req = 1'b0;
        tick;
    endtask

    task automatic test_both_same_cycle;
        logic exp_i;
        logic exp_d;
        grant_q.delete();
        tests_run++;
        if (inst_rdata !== 32'h24080001) begin tests_failed++; $display("FAIL both_rdata_kept: got %h expected 24080001", inst_rdata); end
        inst_req  = 1'b1;
        inst_addr = 32'hBFC00004;
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'd2;
        data_addr = 32'h80001000;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) tick; else #1;
            exp_d = (c <= 2);
            exp_i = (c <= 5);
            tests_run++;
            if (i_stall !== exp_i || d_stall !== exp_d) begin
                tests_failed++;
                $display("FAIL both_stall_c%0d: got i=%b d=%b expected i=%b d=%b", c, i_stall, d_stall, exp_i, exp_d);
            end
            if (c == 4) begin
                tests_run++;
                if (mem_req !== 1'b1 || mem_addr !== 32'hBFC00004) begin tests_failed++; $display("FAIL both_b2b_c4: got %b %h expected 1 bfc00004", mem_req, mem_addr); end
            end
        end
        tests_run++;
        if (data_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL both_data_rdata: got %h expected deadbeef", data_rdata); end
        tests_run++;
        if (inst_rdata !== 32'hE59A5A5E) begin tests_failed++; $display("FAIL both_inst_rdata: got %h expected e59a5a5e", inst_rdata); end
        tests_run++;
        if (grant_q.size() != 2 || grant_q[0] !== 32'h80001000 || grant_q[1] !== 32'hBFC00004) begin
            tests_failed++;
            $display("FAIL both_order: got %0d grants first %h expected 2 grants data first 80001000", grant_q.size(), (grant_q.size() > 0) ? grant_q[0] : 32'h0);
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        tick;
    endtask

    task automatic test_store;
        addr_lat   = 3;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd0;
        data_addr  = 32'h80000003;
        data_wdata = 32'h000000AB;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) tick; else #1;
            if (c >= 1 && c <= 4) begin
                tests_run++;
                if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_size !== 2'd0 ||
                    mem_addr !== 32'h80000003 || mem_wdata !== 32'h000000AB) begin
                    tests_failed++;
                    $display("FAIL store_hold_c%0d: got req=%b wr=%b size=%0d addr=%h wdata=%h expected 1 1 0 80000003 000000ab",
                             c, mem_req, mem_wr, mem_size, mem_addr, mem_wdata);
                end
            end
            tests_run++;
            if (d_stall !== (c <= 5)) begin tests_failed++; $display("FAIL store_stall_c%0d: got %b expected %b", c, d_stall, (c <= 5)); end
        end
        tests_run++;
        if (data_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL store_rdata_kept: got %h expected deadbeef", data_rdata); end
        data_req = 1'b0;
        data_wr  = 1'b0;
        addr_lat = 0;
        tick;
    endtask

    task automatic test_slow_memory;
        addr_lat  = 4;
        data_lat  = 4;
        inst_req  = 1'b1;
        inst_addr = 32'h80002000;
        for (int c = 0; c <= 11; c++) begin
            if (c > 0) tick; else #1;
            tests_run++;
            if (mem_req !== (c >= 1 && c <= 5) || i_stall !== (c <= 10)) begin
                tests_failed++;
                $display("FAIL slow_c%0d: got req=%b i_stall=%b expected %b %b", c, mem_req, i_stall, (c >= 1 && c <= 5), (c <= 10));
            end
            if (c >= 1) begin
                tests_run++;
                if (mem_addr !== 32'h80002000) begin tests_failed++; $display("FAIL slow_addr_c%0d: got %h expected 80002000", c, mem_addr); end
            end
        end
        tests_run++;
        if (inst_rdata !== 32'hDA5A7A5A) begin tests_failed++; $display("FAIL slow_rdata: got %h expected da5a7a5a", inst_rdata); end
        inst_req = 1'b0;
        addr_lat = 0;
        data_lat = 0;
        tick;
    endtask

    task automatic test_req_dropped;
        ls_auto   = 1'b0;
        ls_manual = 1'b1;
        addr_lat  = 0;
        data_lat  = 2;
        inst_req  = 1'b1;
        inst_addr = 32'h80003000;
        #1;
        tick;
        tick;
        inst_req = 1'b0;       // withdrawn while in WAIT
        tick;
        tick;                  // mem_data_ok in this cycle
        tick;
        tests_run++;
        if (inst_rdata !== 32'hDA5A7A5A || mem_req !== 1'b0) begin tests_failed++; $display("FAIL drop_discard: got rdata=%h req=%b expected da5a7a5a 0", inst_rdata, mem_req); end
        data_lat = 0;
        inst_req = 1'b1;
        #1;
        tests_run++;
        if (i_stall !== 1'b1) begin tests_failed++; $display("FAIL drop_no_done: got i_stall=%b expected 1", i_stall); end
        tick;
        tests_run++;
        if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL drop_regrant: got %b expected 1", mem_req); end
        tick;
        tick;
        tests_run++;
        if (i_stall !== 1'b0 || inst_rdata !== 32'hDA5A6A5A) begin tests_failed++; $display("FAIL drop_refetch: got %b %h expected 0 da5a6a5a", i_stall, inst_rdata); end
        inst_req = 1'b0;
        ls_auto  = 1'b1;
        tick;
    endtask

    task automatic test_reset_in_wait;
        addr_lat  = 0;
        data_lat  = 3;
        inst_req  = 1'b1;
        inst_addr = 32'h80004000;
        #1;
        tick;
        tick;
        tick;                  // in WAIT; data arrives two cycles from now
        rst      = 1'b1;
        inst_req = 1'b0;
        tick;
        rst = 1'b0;
        tests_run++;
        if (mem_req !== 1'b0 || mem_addr !== 32'd0 || i_stall !== 1'b0) begin tests_failed++; $display("FAIL rstwait_idle: got req=%b addr=%h i_stall=%b expected 0 0 0", mem_req, mem_addr, i_stall); end
        tests_run++;
        if (inst_rdata !== 32'd0 || data_rdata !== 32'd0) begin tests_failed++; $display("FAIL rstwait_rdata: got %h/%h expected 0/0", inst_rdata, data_rdata); end
        tick;                  // late mem_data_ok in this cycle
        tick;
        tests_run++;
        if (inst_rdata !== 32'd0 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL rstwait_late_ok: got rdata=%h req=%b expected 0 0", inst_rdata, mem_req); end
        data_lat  = 0;
        inst_req  = 1'b1;
        inst_addr = 32'h80005000;
        #1;
        tests_run++;
        if (i_stall !== 1'b1) begin tests_failed++; $display("FAIL rstwait_done_clear: got i_stall=%b expected 1", i_stall); end
        tick;
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h80005000) begin tests_failed++; $display("FAIL rstwait_regrant: got %b %h expected 1 80005000", mem_req, mem_addr); end
        tick;
        tick;
        tests_run++;
        if (i_stall !== 1'b0 || inst_rdata !== 32'hDA5A0A5A) begin tests_failed++; $display("FAIL rstwait_fetch: got %b %h expected 0 da5a0a5a", i_stall, inst_rdata); end
        inst_req = 1'b0;
        tick;
    endtask

`ifdef MEM_ARB_ROUND_ROBIN_EN
    task automatic test_round_robin;
        int k;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        grant_q.delete();
        inst_req  = 1'b1;
        inst_addr = 32'h80006000;
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'd2;
        data_addr = 32'h80007000;
        #1;
        k = 0;
        while (k < 20 && (i_stall || d_stall)) begin tick; k++; end
        tests_run++;
        if (k != 6) begin tests_failed++; $display("FAIL rr_round1_cycles: got %0d expected 6", k); end
        // Next pipeline cycle: both still requesting, new addresses.
        inst_addr = 32'h80008000;
        data_addr = 32'h80009000;
        tick;
        k = 0;
        while (k < 20 && (i_stall || d_stall)) begin tick; k++; end
        tests_run++;
        if (k >= 20) begin tests_failed++; $display("FAIL rr_round2_timeout: got %0d cycles expected under 20", k); end
        tests_run++;
        if (grant_q.size() != 4 || grant_q[0] !== 32'h80007000 || grant_q[1] !== 32'h80006000 ||
            grant_q[2] !== 32'h80008000 || grant_q[3] !== 32'h80009000) begin
            tests_failed++;
            $display("FAIL rr_order: got %0d grants expected 4 in order 80007000 80006000 80008000 80009000", grant_q.size());
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        tick;
    endtask
`endif

    // ---------------- sequence and final report ----------------
    initial begin
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        test_reset;
        test_single_fetch;
        test_both_same_cycle;
        test_store;
        test_slow_memory;
        test_req_dropped;
        test_reset_in_wait;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        test_round_robin;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
